// File: rtl/serial_pkg.sv
// Shared constants and helpers for the serial IP FIFOs.
package serial_pkg;

  localparam int DEFAULT_DATA_WIDTH = 9;
  localparam int DEFAULT_DEPTH      = 16;

  // Number of address bits needed to index a FIFO of the given depth.
  // A depth of one still gets a single address bit, so that slices stay legal.
  function automatic int FIFO_IDX_W(input int depth);
    if (depth <= 1) begin
      return 1;
    end
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: pulses high for the first cycle a level input is seen high.
module edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_d1;

  // Remember last cycle's level; history starts low so a request held through reset counts as new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_d1 <= 1'b0;
    end else begin
      sig_d1 <= sig;
    end
  end

  assign rise = sig & ~sig_d1;

endmodule

// File: rtl/serial_fifo_param.sv
// Parametrised synchronous first-word-fall-through FIFO for the serial TX/RX paths,
// with sticky overflow/underflow flags, flush, watermark interrupt and peak tracking.
module serial_fifo_param
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter bit EDGE_REQUESTS = 1'b1,
  localparam int AW           = FIFO_IDX_W(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_request,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_request,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  flush,
  input  logic                  clear_overflow_request,
  input  logic                  clear_underflow_request,
  input  logic                  clear_peak_request,
  input  logic [AW:0]           watermark_level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [AW:0]           count,
  output logic [AW:0]           peak,
  output logic [AW:0]           wr_index,
  output logic [AW:0]           rd_index,
  output logic                  watermark_irq
);

  localparam logic [AW:0] PTR_ZERO = '0;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  // Storage is deliberately left without reset so it maps onto distributed RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Requests after optional edge qualification.
  logic q_wr;
  logic q_rd;
  logic q_clear_overflow;
  logic q_clear_underflow;
  logic q_clear_peak;

  // Operations actually performed this cycle.
  logic        do_push;
  logic        do_pop;
  logic        overflow_set;
  logic        underflow_set;
  logic [AW:0] push_inc;
  logic [AW:0] pop_dec;
  logic [AW:0] count_next;

  // Edge-qualify every request input so a held request acts once; in level mode pass straight through.
  generate
    if (EDGE_REQUESTS) begin : g_edge
      edge_detector u_wr_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (wr_request),
        .rise  (q_wr)
      );
      edge_detector u_rd_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (rd_request),
        .rise  (q_rd)
      );
      edge_detector u_clr_ovf_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (clear_overflow_request),
        .rise  (q_clear_overflow)
      );
      edge_detector u_clr_unf_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (clear_underflow_request),
        .rise  (q_clear_underflow)
      );
      edge_detector u_clr_peak_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (clear_peak_request),
        .rise  (q_clear_peak)
      );
    end else begin : g_level
      assign q_wr              = wr_request;
      assign q_rd              = rd_request;
      assign q_clear_overflow  = clear_overflow_request;
      assign q_clear_underflow = clear_underflow_request;
      assign q_clear_peak      = clear_peak_request;
    end
  endgenerate

  // Occupancy is derived from the pointers; the extra wrap bit separates full from empty.
  always_comb begin
    empty = (wr_index == rd_index);
    full  = (wr_index[AW] != rd_index[AW]) && (wr_index[AW-1:0] == rd_index[AW-1:0]);
    count = wr_index - rd_index;
  end

  // Decide which operations happen; flush overrides everything and suppresses the error flags.
  // A write while full is still accepted when a read frees the head slot in the same cycle.
  always_comb begin
    do_push       = ~flush & q_wr & (~full | q_rd);
    do_pop        = ~flush & q_rd & ~empty;
    overflow_set  = ~flush & q_wr & full & ~q_rd;
    underflow_set = ~flush & q_rd & empty;
    push_inc      = {{AW{1'b0}}, do_push};
    pop_dec       = {{AW{1'b0}}, do_pop};
    if (flush) begin
      count_next = PTR_ZERO;
    end else begin
      count_next = count + push_inc - pop_dec;
    end
  end

  // Write port of the storage array; only accepted pushes write.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_index[AW-1:0]] <= wr_data;
    end
  end

  // Head entry is visible combinationally so the consumer sees data with no read latency.
  assign rd_data = mem[rd_index[AW-1:0]];

  // Advance the pointers; they wrap naturally modulo twice the depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_index <= PTR_ZERO;
      rd_index <= PTR_ZERO;
    end else if (flush) begin
      wr_index <= PTR_ZERO;
      rd_index <= PTR_ZERO;
    end else begin
      if (do_push) begin
        wr_index <= wr_index + PTR_ONE;
      end
      if (do_pop) begin
        rd_index <= rd_index + PTR_ONE;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle wins over a clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (q_clear_overflow) begin
        overflow <= 1'b0;
      end
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (q_clear_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

  // Track the highest occupancy reached; a clear restarts tracking from the upcoming count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak <= PTR_ZERO;
    end else if (q_clear_peak) begin
      peak <= count_next;
    end else if (count_next > peak) begin
      peak <= count_next;
    end
  end

  // Watermark interrupt follows the registered count, so it trails a count change by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      watermark_irq <= 1'b0;
    end else begin
      watermark_irq <= (watermark_level != PTR_ZERO) && (count >= watermark_level);
    end
  end

endmodule

// File: tb/tb_serial_fifo_param.sv
// Self-checking bench for serial_fifo_param: directed scenarios plus random traffic,
// all compared against a queue-based reference model; a second level-mode instance is also exercised.
module tb_serial_fifo_param;

  localparam int DW    = 9;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          wr_request;
  logic [DW-1:0] wr_data;
  logic          rd_request;
  logic          flush;
  logic          clear_overflow_request;
  logic          clear_underflow_request;
  logic          clear_peak_request;
  logic [AW:0]   watermark_level;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic [AW:0]   count;
  logic [AW:0]   peak;
  logic [AW:0]   wr_index;
  logic [AW:0]   rd_index;
  logic          watermark_irq;

  logic          l_wr_request;
  logic [DW-1:0] l_wr_data;
  logic          l_rd_request;
  logic [DW-1:0] l_rd_data;
  logic          l_empty;
  logic          l_full;
  logic          l_overflow;
  logic          l_underflow;
  logic [AW:0]   l_count;
  logic [AW:0]   l_peak;
  logic [AW:0]   l_wr_index;
  logic [AW:0]   l_rd_index;
  logic          l_watermark_irq;

  serial_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EDGE_REQUESTS(1'b1)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .wr_request              (wr_request),
    .wr_data                 (wr_data),
    .rd_request              (rd_request),
    .rd_data                 (rd_data),
    .flush                   (flush),
    .clear_overflow_request  (clear_overflow_request),
    .clear_underflow_request (clear_underflow_request),
    .clear_peak_request      (clear_peak_request),
    .watermark_level         (watermark_level),
    .empty                   (empty),
    .full                    (full),
    .overflow                (overflow),
    .underflow               (underflow),
    .count                   (count),
    .peak                    (peak),
    .wr_index                (wr_index),
    .rd_index                (rd_index),
    .watermark_irq           (watermark_irq)
  );

  serial_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EDGE_REQUESTS(1'b0)) dut_level (
    .clk                     (clk),
    .reset                   (reset),
    .wr_request              (l_wr_request),
    .wr_data                 (l_wr_data),
    .rd_request              (l_rd_request),
    .rd_data                 (l_rd_data),
    .flush                   (1'b0),
    .clear_overflow_request  (1'b0),
    .clear_underflow_request (1'b0),
    .clear_peak_request      (1'b0),
    .watermark_level         (5'd0),
    .empty                   (l_empty),
    .full                    (l_full),
    .overflow                (l_overflow),
    .underflow               (l_underflow),
    .count                   (l_count),
    .peak                    (l_peak),
    .wr_index                (l_wr_index),
    .rd_index                (l_rd_index),
    .watermark_irq           (l_watermark_irq)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: contents as a queue, flags, and request history.
  int mq[$];
  bit m_ovf;
  bit m_unf;
  bit m_irq;
  int m_peak;
  int m_wi;
  int m_ri;
  bit p_wr;
  bit p_rd;
  bit p_co;
  bit p_cu;
  bit p_cp;

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_irq  = 1'b0;
    m_peak = 0;
    m_wi   = 0;
    m_ri   = 0;
    p_wr   = 1'b0;
    p_rd   = 1'b0;
    p_co   = 1'b0;
    p_cu   = 1'b0;
    p_cp   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit qw, qr, qco, qcu, qcp;
    bit oset, uset, irq_n, was_full, was_empty;
    if (!reset) begin
      modelReset();
      return;
    end
    qw  = wr_request && !p_wr;
    qr  = rd_request && !p_rd;
    qco = clear_overflow_request && !p_co;
    qcu = clear_underflow_request && !p_cu;
    qcp = clear_peak_request && !p_cp;
    p_wr = wr_request;
    p_rd = rd_request;
    p_co = clear_overflow_request;
    p_cu = clear_underflow_request;
    p_cp = clear_peak_request;
    irq_n = (watermark_level != 0) && (mq.size() >= int'(watermark_level));
    oset = 1'b0;
    uset = 1'b0;
    if (flush) begin
      mq.delete();
      m_wi = 0;
      m_ri = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      oset = qw && was_full && !qr;
      uset = qr && was_empty;
      if (qr && !was_empty) begin
        void'(mq.pop_front());
        m_ri = (m_ri + 1) % (2 * DEPTH);
      end
      if (qw && (!was_full || qr)) begin
        mq.push_back(int'(wr_data));
        m_wi = (m_wi + 1) % (2 * DEPTH);
      end
    end
    if (oset) m_ovf = 1'b1;
    else if (qco) m_ovf = 1'b0;
    if (uset) m_unf = 1'b1;
    else if (qcu) m_unf = 1'b0;
    if (qcp) m_peak = mq.size();
    else if (mq.size() > m_peak) m_peak = mq.size();
    m_irq = irq_n;
  endtask

  task automatic checkAll();
    checkOutput("count", 32'(count), 32'(mq.size()));
    checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("wr_index", 32'(wr_index), 32'(m_wi));
    checkOutput("rd_index", 32'(rd_index), 32'(m_ri));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("underflow", 32'(underflow), 32'(m_unf));
    checkOutput("peak", 32'(peak), 32'(m_peak));
    checkOutput("irq", 32'(watermark_irq), 32'(m_irq));
    if (mq.size() > 0) checkOutput("rd_data", 32'(rd_data), 32'(mq[0]));
  endtask

  // Drive one cycle of inputs, step the model, clock, then compare just after the edge.
  task automatic applyStimulus(input bit wr, input int wd, input bit rd, input bit fl,
                               input bit co, input bit cu, input bit cp);
    wr_request              = wr;
    wr_data                 = DW'(wd);
    rd_request              = rd;
    flush                   = fl;
    clear_overflow_request  = co;
    clear_underflow_request = cu;
    clear_peak_request      = cp;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_count"}, 32'(count), 0);
    checkOutput({tag, "_empty"}, 32'(empty), 1);
    checkOutput({tag, "_full"}, 32'(full), 0);
    checkOutput({tag, "_peak"}, 32'(peak), 0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 0);
    checkOutput({tag, "_unf"}, 32'(underflow), 0);
    checkOutput({tag, "_irq"}, 32'(watermark_irq), 0);
    checkOutput({tag, "_wr_index"}, 32'(wr_index), 0);
    checkOutput({tag, "_rd_index"}, 32'(rd_index), 0);
  endtask

  initial begin
    int saved_ri;
    reset = 1'b0;
    wr_request = 1'b0; wr_data = '0; rd_request = 1'b0; flush = 1'b0;
    clear_overflow_request = 1'b0; clear_underflow_request = 1'b0; clear_peak_request = 1'b0;
    watermark_level = '0;
    l_wr_request = 1'b0; l_wr_data = '0; l_rd_request = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b1;

    // Fill with sixteen pulsed writes.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 'h100 + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
    end
    checkOutput("fill_full", 32'(full), 1);
    checkOutput("fill_count", 32'(count), 16);
    checkOutput("fill_wr_index", 32'(wr_index), 16);
    checkOutput("fill_rd_data", 32'(rd_data), 'h100);
    checkOutput("fill_peak", 32'(peak), 16);

    // Write while full is dropped and sets overflow; a clear pulse removes it.
    applyStimulus(1'b1, 'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    checkOutput("ovf_set", 32'(overflow), 1);
    checkOutput("ovf_count", 32'(count), 16);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_clear", 32'(overflow), 0);
    idle();

    // Simultaneous read and write while full keeps it full and advances the head.
    applyStimulus(1'b1, 'h0AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rw_full_count", 32'(count), 16);
    checkOutput("rw_full_head", 32'(rd_data), 'h101);
    checkOutput("rw_full_flag", 32'(full), 1);
    idle();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 'h0AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
    end
    checkOutput("wrap_wr_index", 32'(wr_index), 0);

    // Drain everything; the model checks each head value including the trailing 0x0AA.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
    end
    checkOutput("drain_empty", 32'(empty), 1);

    // Read while empty sets underflow; a same-cycle write still lands.
    saved_ri = int'(rd_index);
    applyStimulus(1'b1, 'h055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("unf_set", 32'(underflow), 1);
    checkOutput("unf_rd_index", 32'(rd_index), 32'(saved_ri));
    checkOutput("unf_count", 32'(count), 1);
    checkOutput("unf_rd_data", 32'(rd_data), 'h055);
    idle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("unf_clear", 32'(underflow), 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Watermark at four: irq trails the count by a cycle in both directions.
    watermark_level = 5'd4;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle();
      applyStimulus(1'b1, 'h010 + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("wm_count4", 32'(count), 4);
    checkOutput("wm_irq_lag", 32'(watermark_irq), 0);
    idle();
    checkOutput("wm_irq_set", 32'(watermark_irq), 1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wm_irq_hold", 32'(watermark_irq), 1);
    idle();
    checkOutput("wm_irq_clr", 32'(watermark_irq), 0);
    watermark_level = 5'd0;
    applyStimulus(1'b1, 'h020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    checkOutput("wm_disabled", 32'(watermark_irq), 0);
    watermark_level = 5'd20;
    idle();
    idle();
    checkOutput("wm_above_depth", 32'(watermark_irq), 0);

    // Flush wins over a same-cycle write and leaves peak alone.
    applyStimulus(1'b1, 'h133, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_count", 32'(count), 0);
    checkOutput("flush_empty", 32'(empty), 1);
    checkOutput("flush_peak", 32'(peak), 16);
    idle();

    // Level-mode instance: a held request acts every cycle.
    l_wr_request = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      l_wr_data = DW'(i);
      idle();
    end
    l_wr_request = 1'b0;
    checkOutput("lvl_count3", 32'(l_count), 3);
    checkOutput("lvl_head", 32'(l_rd_data), 1);
    l_rd_request = 1'b1;
    idle();
    idle();
    l_rd_request = 1'b0;
    checkOutput("lvl_count1", 32'(l_count), 1);
    checkOutput("lvl_head_after", 32'(l_rd_data), 3);

    // Random traffic with phase-varying bias so the FIFO swings between empty and full.
    for (int i = 0; i < 1600; i++) begin
      int wbias;
      wbias = ((i / 200) % 2 == 0) ? 80 : 25;
      if (i % 100 == 0) watermark_level = AW'(0) + 5'($urandom_range(0, 20));
      applyStimulus($urandom_range(0, 99) < wbias, int'($urandom_range(0, 511)),
                    $urandom_range(0, 99) < (100 - wbias), $urandom_range(0, 79) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 31) == 0);
    end

    // Reset in the middle of a burst returns everything to reset values at once.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 'h0C0 + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
    end
    applyStimulus(1'b1, 'h0CF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async_reset");
    modelReset();
    applyStimulus(1'b1, 'h0D0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 'h0D1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_count", 32'(count), 1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
